// File: rtl/ro_counter_pkg.sv
// ro_counter_pkg: shared FSM state encoding and default sizing for the ring-oscillator frequency counter.
package ro_counter_pkg;
   localparam int CH_DEF     = 4;
   localparam int W_DEF      = 16;
   localparam int GATE_W_DEF = 20;
   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t ARM   = 2'd1;
   localparam state_t GATE  = 2'd2;
   localparam state_t LATCH = 2'd3;
endpackage

// File: rtl/ro_edge_channel.sv
// ro_edge_channel: synchronise one ring-oscillator output and count its rising edges with saturation.
module ro_edge_channel #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ro,
   input  logic         clear,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         sat
);
   logic [1:0]   sync_q, sync_d;
   logic         edge_q, edge_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic         sat_q, sat_d;
   logic         hit, full;
   always_comb begin
      sync_d = {sync_q[0], ro};
      edge_d = sync_q[1];
      hit    = en & sync_q[1] & ~edge_q;
      full   = &cnt_q;
      cnt_d  = clear ? '0 : (hit & ~full) ? cnt_q + W'(1) : cnt_q;
      // sat marks an edge lost because the counter was already pinned at all-ones
      sat_d  = clear ? 1'b0 : sat_q | (hit & full);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         edge_q <= 1'b0;
         cnt_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         edge_q <= edge_d;
         cnt_q  <= cnt_d;
         sat_q  <= sat_d;
      end
   end
   assign cnt = cnt_q;
   assign sat = sat_q;
endmodule

// File: rtl/ro_freq_counter.sv
// ro_freq_counter: multi-channel gated ring-oscillator frequency counter with start/done handshake.
module ro_freq_counter
   import ro_counter_pkg::*;
#(
   parameter int CH     = CH_DEF,
   parameter int W      = W_DEF,
   parameter int GATE_W = GATE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [GATE_W-1:0] gate_len,
   input  logic [CH-1:0]     ro_in,
   output logic              busy,
   output logic              done,
   output logic [CH*W-1:0]   count,
   output logic [CH-1:0]     sat
);
   state_t            state_q, state_d;
   logic [GATE_W-1:0] gate_q, gate_d;
   logic              done_q, done_d;
   logic [CH*W-1:0]   count_q, count_d;
   logic [CH-1:0]     sat_q, sat_d;
   logic [CH*W-1:0]   cnt_all;
   logic [CH-1:0]     sat_all;
   logic              arm, gating, accept;
   assign arm    = state_q == ARM;
   assign gating = state_q == GATE;
   assign accept = (state_q == IDLE) & start;
   for (genvar i = 0; i < CH; i++) begin : g_ch
      ro_edge_channel #(.W(W)) u_ch (
         .clk   (clk),
         .rst   (rst),
         .ro    (ro_in[i]),
         .clear (arm),
         .en    (gating),
         .cnt   (cnt_all[i*W +: W]),
         .sat   (sat_all[i])
      );
   end
   always_comb begin
      state_d = (state_q == IDLE) ? (start ? ARM : IDLE) :
                (state_q == ARM)  ? GATE :
                (state_q == GATE) ? ((gate_q == GATE_W'(1)) ? LATCH : GATE) : IDLE;
      // the gate counter is loaded on acceptance and holds through ARM, so GATE lasts exactly L cycles
      gate_d  = accept ? ((gate_len == '0) ? GATE_W'(1) : gate_len) :
                gating ? gate_q - GATE_W'(1) : gate_q;
      done_d  = state_q == LATCH;
      count_d = done_d ? cnt_all : count_q;
      sat_d   = done_d ? sat_all : sat_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gate_q  <= '0;
         done_q  <= 1'b0;
         count_q <= '0;
         sat_q   <= '0;
      end else begin
         state_q <= state_d;
         gate_q  <= gate_d;
         done_q  <= done_d;
         count_q <= count_d;
         sat_q   <= sat_d;
      end
   end
   assign busy  = state_q != IDLE;
   assign done  = done_q;
   assign count = count_q;
   assign sat   = sat_q;
endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: scoreboard bench for the gated ring-oscillator frequency counter.
`timescale 1ns/1ps
module tb_ro_freq_counter;
   typedef struct {
      time t0;
      int  lat;
      int  exp0;
      int  exp1;
      int  tol;
      bit  chk4;
      int  e4;
      int  t4;
      bit  s4;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [19:0] gate_len = '0;
   logic        ro0 = 1'b0;
   logic        ro1 = 1'b0;
   logic [1:0]  ro_en = '0;
   logic [3:0]  ro_in;
   logic        busy, done, busy4, done4, sat4;
   logic [63:0] count;
   logic [3:0]  sat, count4;
   exp_t        sb[$];
   exp_t        e;
   int          n_tests = 0;
   int          n_fail = 0;
   int          n_done = 0;
   assign ro_in = {2'b00, ro1, ro0};
   ro_freq_counter dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .gate_len (gate_len),
      .ro_in    (ro_in),
      .busy     (busy),
      .done     (done),
      .count    (count),
      .sat      (sat)
   );
   ro_freq_counter #(.CH(1), .W(4), .GATE_W(20)) dut4 (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .gate_len (gate_len),
      .ro_in    (ro0),
      .busy     (busy4),
      .done     (done4),
      .count    (count4),
      .sat      (sat4)
   );
   always #5 clk = ~clk;
   // oscillators deliberately offset from clk edges: ch0 period 40 ns, ch1 period 100 ns
   initial begin
      #3;
      forever begin
         #20;
         ro0 = ro_en[0] ? ~ro0 : 1'b0;
      end
   end
   initial begin
      #7;
      forever begin
         #50;
         ro1 = ro_en[1] ? ~ro1 : 1'b0;
      end
   end
   task automatic chk(input string tag, input int got, input int exp, input int tol);
      n_tests++;
      if (got > exp + tol || got < exp - tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, got, exp, tol);
      end
   endtask
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) chk("spurious_done", 1, 0, 0);
         else begin
            e = sb.pop_front();
            chk("latency", int'(($time - e.t0 - 5) / 10), e.lat, 0);
            chk("count0", int'(count[15:0]), e.exp0, e.tol);
            chk("count1", int'(count[31:16]), e.exp1, e.tol);
            chk("count2", int'(count[47:32]), 0, 0);
            chk("count3", int'(count[63:48]), 0, 0);
            chk("sat", int'(sat), 0, 0);
            chk("busy_in_done", int'(busy), 0, 0);
            chk("done4", int'(done4), 1, 0);
            if (e.chk4) begin
               chk("count4", int'(count4), e.e4, e.t4);
               chk("sat4", int'(sat4), int'(e.s4), 0);
            end
         end
         n_done++;
      end
   end
   task automatic push(input time t0, input int len, input int e0, input int e1, input int tol,
                       input bit c4 = 0, input int e4 = 0, input int t4 = 0, input bit s4 = 0);
      exp_t x;
      x.t0 = t0; x.lat = ((len == 0) ? 1 : len) + 2;
      x.exp0 = e0; x.exp1 = e1; x.tol = tol;
      x.chk4 = c4; x.e4 = e4; x.t4 = t4; x.s4 = s4;
      sb.push_back(x);
   endtask
   task automatic launch(input int len, input int e0, input int e1, input int tol,
                         input bit c4 = 0, input int e4 = 0, input int t4 = 0, input bit s4 = 0);
      @(posedge clk);
      #1 start = 1'b1;
      gate_len = 20'(len);
      @(posedge clk);
      push($time, len, e0, e1, tol, c4, e4, t4, s4);
      #1 start = 1'b0;
      chk("busy_after_start", int'(busy), 1, 0);
   endtask
   task automatic wait_done(input int target, input int budget);
      int k = 0;
      while (n_done < target && k < budget) begin
         @(posedge clk);
         k++;
      end
      if (n_done < target) chk("timeout", n_done, target, 0);
   endtask
   task automatic run(input int len, input int e0, input int e1, input int tol,
                      input bit c4 = 0, input int e4 = 0, input int t4 = 0, input bit s4 = 0);
      launch(len, e0, e1, tol, c4, e4, t4, s4);
      wait_done(n_done + 1, len + 20);
   endtask
   initial begin
      time t0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", int'(busy), 0, 0);
      chk("rst_done", int'(done), 0, 0);
      for (int i = 0; i < 4; i++) chk("rst_count", int'(count[i*16 +: 16]), 0, 0);
      chk("rst_sat", int'(sat), 0, 0);
      run(100, 0, 0, 0);
      ro_en = 2'b11;
      repeat (10) @(posedge clk);
      run(1000, 250, 100, 1);
      ro_en = 2'b01;
      run(200, 50, 0, 1, 1, 15, 0, 1);
      run(20, 5, 0, 1, 1, 5, 1, 0);
      ro_en = 2'b00;
      repeat (10) @(posedge clk);
      launch(100, 0, 0, 0);
      repeat (30) @(posedge clk);
      #1 start = 1'b1;
      gate_len = 20'd5;
      @(posedge clk);
      #1 start = 1'b0;
      chk("busy_mid_window", int'(busy), 1, 0);
      wait_done(n_done + 1, 120);
      repeat (20) @(posedge clk);
      ro_en = 2'b01;
      @(posedge clk);
      #1 start = 1'b1;
      gate_len = 20'd10;
      @(posedge clk);
      t0 = $time;
      push(t0, 10, 2, 0, 1);
      push(t0 + 130, 10, 2, 0, 1);
      wait_done(n_done + 1, 40);
      #1 start = 1'b0;
      chk("busy_back_to_back", int'(busy), 1, 0);
      wait_done(n_done + 1, 40);
      @(posedge clk);
      #1 start = 1'b1;
      gate_len = 20'd200;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (50) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0, 0);
      chk("abort_done", int'(done), 0, 0);
      chk("abort_count0", int'(count[15:0]), 0, 0);
      chk("abort_sat", int'(sat), 0, 0);
      chk("abort_busy4", int'(busy4), 0, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (250) @(posedge clk);
      run(20, 5, 0, 1);
      ro_en = 2'b00;
      repeat (10) @(posedge clk);
      run(0, 0, 0, 0);
      repeat (5) @(posedge clk);
      if (sb.size() != 0) chk("sb_empty", sb.size(), 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
   initial begin
      #1ms;
      $display("FAIL watchdog: got no finish, want finish within 1 ms");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/ro_freq_counter.md
# ro_freq_counter

Multi-channel gated frequency counter for the ring-oscillator array. Each channel synchronises one free-running ring-oscillator output into the system clock domain and counts its rising edges over a programmable gate window of `clk` cycles. At the end of the window it latches per-channel results with saturation flags. It generalises the free-running single counter to N channels with width, window, start/done handshake and overflow detection, and it sits between the oscillator bank and the readout/control logic.

## Interface
- `CH`, 4, number of ring-oscillator channels (≥1)
- `W`, 16, per-channel count width in bits (≥2)
- `GATE_W`, 20, width of the gate-length field
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `start`  in  1  request a measurement; sampled only in IDLE
- `gate_len`  in  GATE_W  window length in `clk` cycles; captured when `start` is accepted; 0 is treated as 1
- `ro_in`  in  CH  raw ring-oscillator outputs, asynchronous to `clk`
- `busy`  out  1  measurement in progress
- `done`  out  1  single-cycle pulse: `count`/`sat` updated
- `count`  out  CH*W  channel i result in bits [i*W +: W]
- `sat`  out  CH  channel i counter saturated during last window

## Operation
- Reset: state IDLE; `busy`=0, `done`=0, `count`=0, `sat`=0; synchronisers, edge registers, channel counters and gate counter all 0.
- Per channel: 2-flop synchroniser, then edge register; edge = sync_q & ~edge_q.
- FSM states:
  - IDLE: if `start`=1, capture `gate_len` (0→1) and go to ARM. Otherwise stay.
  - ARM: clear all channel counters and `sat` accumulators; load gate counter; go to GATE.
  - GATE: each channel increments on each detected edge; gate counter decrements; after exactly captured-length cycles in GATE, go to LATCH.
  - LATCH: register counters into `count` and saturation into `sat`; assert `done` for the following cycle; go to IDLE.
- Saturation: counter at all-ones holds at all-ones. The channel sat bit is set and stays set until the next ARM.
- `count`/`sat` hold their previous values from one `done` to the next.
- `start` while `busy`=1 is ignored; no queueing.
- `gate_len` changes after acceptance have no effect on the running window.
- Reset asserted mid-measurement aborts it: all outputs return to reset values, with no `done`.
- Edges are counted only while in GATE; edges in ARM/LATCH/IDLE are discarded.
- Accuracy: each channel requires an oscillator frequency < f_clk/2 after any on-chip divider. Result error is ±1 count from window alignment.

## Timing
- `start` sampled at edge 0 → ARM after edge 0, GATE after edge 1, GATE lasts L = max(`gate_len`,1) cycles, LATCH after edge L+1.
- `done`=1 and new `count`/`sat` visible after edge L+2, i.e. L+2 cycles after `start` sampled.
- `busy`=1 from after edge 0 through LATCH; `busy`=0 in the same cycle `done`=1.
- `start` high in the `done` cycle is accepted (back-to-back measurements, L+2 cycle period).
- Input-to-edge latency: 3 `clk` cycles (2 sync + edge register).

## Structure
- Package `ro_counter_pkg`: FSM state enum (IDLE, ARM, GATE, LATCH) and default values of `CH`, `W`, `GATE_W`.
- Sub-module `ro_edge_channel` (parameter `W`): synchroniser, edge detector, saturating counter, sticky sat; inputs `clk`, `rst`, `ro`, `clear`, `en`.
- Top instantiates `CH` channels via generate, plus FSM and gate down-counter.

## Test plan
- `ro_in` held 0, `gate_len`=100 → `done` exactly 102 cycles after `start`; all `count`=0, `sat`=0.
- Channel 0 square wave period 4 clk, channel 1 period 10 clk, `gate_len`=1000 → count0=250±1, count1=100±1, others 0.
- `W`=4, period 4 clk, `gate_len`=200 → count=15, sat=1. Next run with `gate_len`=20 → count=5±1, sat=0.
- Second `start` pulsed mid-window → ignored, single `done`. `start` held in `done` cycle → new run begins, `busy`=1 next cycle.
- `rst` asserted mid-GATE → `busy`=0, `count`=0, `sat`=0 immediately, no `done`. Fresh `start` then completes normally.
- `gate_len`=0 → behaves as 1; `done` 3 cycles after `start`.
